// File: rtl/axis_pkt_gen_pkg.sv
// Shared types for the AXI4-Stream packet generator: pattern modes, FSM states, length clamp.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package axis_pkt_gen_pkg;

    // Data pattern selection; the reserved code behaves like MODE_INCR
    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_TAG   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // A zero length still produces a one-beat packet; oversize lengths saturate
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) return 1;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle between the packet generator and its sink.
// Latency: none (wires only).
// Backpressure: tready from the slave side; tkeep present only with AXIS_PKT_GEN_TKEEP_EN.
interface axis_pkt_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
`ifdef AXIS_PKT_GEN_TKEEP_EN
    logic [DATA_WIDTH/8-1:0] tkeep;
`endif

    modport master (
        output tdata,
        output tvalid,
        output tlast,
`ifdef AXIS_PKT_GEN_TKEEP_EN
        output tkeep,
`endif
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
`ifdef AXIS_PKT_GEN_TKEEP_EN
        input  tkeep,
`endif
        output tready
    );

endinterface

// File: rtl/axis_pkt_pattern.sv
// Beat data generator: maps (mode, seed, beat index, packet number) to tdata.
// Latency: combinational; the caller registers the result.
// Backpressure: none, pure function of its inputs.
module axis_pkt_pattern
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 9
) (
    input  mode_t                 mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_W-1:0]      beat,
    input  logic [15:0]           pkt,
    output logic [DATA_WIDTH-1:0] data
);
    localparam int HALF = DATA_WIDTH / 2;
    localparam logic [DATA_WIDTH-1:0] LO_MASK = {{HALF{1'b0}}, {HALF{1'b1}}};

    // Tagged mode: packet number in the upper half, beat index in the lower half
    always_comb begin
        data = seed + DATA_WIDTH'(beat);
        case (mode)
            MODE_CONST: data = seed;
            MODE_TAG:   data = (DATA_WIDTH'(pkt) << HALF) | (DATA_WIDTH'(beat) & LO_MASK);
            default:    ;
        endcase
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: run-time length/count/gap/pattern; optional tkeep via AXIS_PKT_GEN_TKEEP_EN.
// Latency: first beat valid one cycle after cfg_start; back-to-back packets when gap is zero.
// Backpressure: beat held stable until tvalid && tready; tready is ignored while tvalid is low.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PKT_LEN = 256,
    parameter int LEN_W       = $clog2(MAX_PKT_LEN + 1),
    parameter int GAP_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [1:0]              cfg_mode,
    input  logic [LEN_W-1:0]        cfg_pkt_len,
    input  logic [15:0]             cfg_num_pkts,
    input  logic [GAP_W-1:0]        cfg_gap,
    input  logic [DATA_WIDTH-1:0]   cfg_seed,
`ifdef AXIS_PKT_GEN_TKEEP_EN
    input  logic [DATA_WIDTH/8-1:0] cfg_last_keep,
`endif
    axis_pkt_gen_if.master          m,
    output logic                    busy,
    output logic [15:0]             pkt_count,
    output logic                    done
);
    state_t                state;
    mode_t                 mode_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      beat;
    logic [15:0]           num_q;
    logic [GAP_W-1:0]      gap_q;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  stop_pend;

    // Next-beat selection feeding the pattern generator
    mode_t                 pat_mode;
    logic [DATA_WIDTH-1:0] pat_seed;
    logic [LEN_W-1:0]      pat_beat;
    logic [15:0]           pat_pkt;
    logic [DATA_WIDTH-1:0] pat_data;
    logic [LEN_W-1:0]      len_sel;
    logic [LEN_W-1:0]      cfg_len_c;
    logic                  last_nxt;
    logic                  hs;
    logic                  run_end;
    logic                  stop_now;

`ifdef AXIS_PKT_GEN_TKEEP_EN
    localparam int KEEP_W = DATA_WIDTH / 8;
    logic [KEEP_W-1:0] keep_q;
    logic [KEEP_W-1:0] cfg_keep_c;
    logic [KEEP_W-1:0] keep_nxt;
`endif

    axis_pkt_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_W      (LEN_W)
    ) u_pattern (
        .mode (pat_mode),
        .seed (pat_seed),
        .beat (pat_beat),
        .pkt  (pat_pkt),
        .data (pat_data)
    );

    // Work out which beat gets presented next: first beat of a run (from live cfg),
    // next beat of this packet, or first beat of the following packet
    always_comb begin
        cfg_len_c = LEN_W'(clamp_len(32'(cfg_pkt_len), 32'(MAX_PKT_LEN)));
        pat_mode  = mode_q;
        pat_seed  = seed_q;
        pat_beat  = '0;
        pat_pkt   = pkt_count;
        len_sel   = len_q;
        case (state)
            ST_IDLE: begin
                pat_mode = mode_t'(cfg_mode);
                pat_seed = cfg_seed;
                pat_pkt  = '0;
                len_sel  = cfg_len_c;
            end
            ST_SEND: begin
                if (!m.tlast) pat_beat = beat + LEN_W'(1);
                else          pat_pkt  = pkt_count + 16'd1;
            end
            default: ;
        endcase
        last_nxt = (pat_beat == len_sel - LEN_W'(1));
        hs       = m.tvalid && m.tready;
        run_end  = (num_q != 16'd0) && ((pkt_count + 16'd1) == num_q);
        stop_now = stop_pend || cfg_stop;
`ifdef AXIS_PKT_GEN_TKEEP_EN
        cfg_keep_c = (cfg_last_keep == '0) ? '1 : cfg_last_keep;
        keep_nxt   = '1;
        if (last_nxt) keep_nxt = (state == ST_IDLE) ? cfg_keep_c : keep_q;
`endif
    end

    // Control FSM with all stream and status outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_INCR;
            len_q     <= '0;
            beat      <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            seed_q    <= '0;
            stop_pend <= 1'b0;
            m.tdata   <= '0;
            m.tvalid  <= 1'b0;
            m.tlast   <= 1'b0;
            busy      <= 1'b0;
            pkt_count <= '0;
            done      <= 1'b0;
`ifdef AXIS_PKT_GEN_TKEEP_EN
            keep_q    <= '0;
            m.tkeep   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Start beats a simultaneous stop; a lone stop does nothing here
                    if (cfg_start) begin
                        mode_q    <= mode_t'(cfg_mode);
                        len_q     <= cfg_len_c;
                        num_q     <= cfg_num_pkts;
                        gap_q     <= cfg_gap;
                        seed_q    <= cfg_seed;
                        stop_pend <= 1'b0;
                        pkt_count <= '0;
                        beat      <= '0;
                        m.tdata   <= pat_data;
                        m.tlast   <= last_nxt;
                        m.tvalid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SEND;
`ifdef AXIS_PKT_GEN_TKEEP_EN
                        keep_q    <= cfg_keep_c;
                        m.tkeep   <= keep_nxt;
`endif
                    end
                end
                ST_SEND: begin
                    if (cfg_stop) stop_pend <= 1'b1;
                    if (hs) begin
                        if (!m.tlast) begin
                            beat    <= pat_beat;
                            m.tdata <= pat_data;
                            m.tlast <= last_nxt;
`ifdef AXIS_PKT_GEN_TKEEP_EN
                            m.tkeep <= keep_nxt;
`endif
                        end else begin
                            pkt_count <= pkt_count + 16'd1;
                            if (run_end || stop_now) begin
                                state     <= ST_IDLE;
                                m.tvalid  <= 1'b0;
                                m.tlast   <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                stop_pend <= 1'b0;
                            end else if (gap_q == '0) begin
                                beat    <= '0;
                                m.tdata <= pat_data;
                                m.tlast <= last_nxt;
`ifdef AXIS_PKT_GEN_TKEEP_EN
                                m.tkeep <= keep_nxt;
`endif
                            end else begin
                                state    <= ST_GAP;
                                m.tvalid <= 1'b0;
                                m.tlast  <= 1'b0;
                                gap_cnt  <= gap_q;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    // gap_cnt was loaded with the gap length, so tvalid stays low exactly that many cycles
                    if (cfg_stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        beat     <= '0;
                        m.tdata  <= pat_data;
                        m.tlast  <= last_nxt;
                        m.tvalid <= 1'b1;
                        state    <= ST_SEND;
`ifdef AXIS_PKT_GEN_TKEEP_EN
                        m.tkeep  <= keep_nxt;
`endif
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    m.tvalid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: back-to-back, stalls, gaps, stop handling, reset, length rules.
// Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
// Transfers and done pulses are logged by a falling-edge monitor into queues/counters.
module tb_axis_pkt_gen;
    localparam int DW   = 32;
    localparam int MAXL = 8;
    localparam int LW   = $clog2(MAXL + 1);
    localparam int GW   = 8;
    localparam int KW   = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [LW-1:0] cfg_pkt_len = '0;
    logic [15:0]   cfg_num_pkts = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic [DW-1:0] cfg_seed = '0;
`ifdef AXIS_PKT_GEN_TKEEP_EN
    logic [KW-1:0] cfg_last_keep = '0;
    logic [KW-1:0] q_keep[$];
`endif
    logic          busy;
    logic [15:0]   pkt_count;
    logic          done;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int done_base = 0;
    logic [DW-1:0] q_data[$];
    logic          q_last[$];

    axis_pkt_gen_if #(.DATA_WIDTH(DW)) m_if ();

    axis_pkt_gen #(
        .DATA_WIDTH  (DW),
        .MAX_PKT_LEN (MAXL),
        .LEN_W       (LW),
        .GAP_W       (GW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_mode     (cfg_mode),
        .cfg_pkt_len  (cfg_pkt_len),
        .cfg_num_pkts (cfg_num_pkts),
        .cfg_gap      (cfg_gap),
        .cfg_seed     (cfg_seed),
`ifdef AXIS_PKT_GEN_TKEEP_EN
        .cfg_last_keep(cfg_last_keep),
`endif
        .m            (m_if.master),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Log every beat that will transfer on the coming edge, and count done pulses
    always @(negedge clk) begin
        if (!reset && m_if.tvalid && m_if.tready) begin
            q_data.push_back(m_if.tdata);
            q_last.push_back(m_if.tlast);
`ifdef AXIS_PKT_GEN_TKEEP_EN
            q_keep.push_back(m_if.tkeep);
`endif
        end
        if (!reset && done === 1'b1) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, need < 400000", $time);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [LW-1:0] len, input logic [15:0] num,
                             input logic [GW-1:0] gap, input logic [DW-1:0] seed);
        cfg_mode = mode; cfg_pkt_len = len; cfg_num_pkts = num; cfg_gap = gap; cfg_seed = seed;
        q_data.delete();
        q_last.delete();
`ifdef AXIS_PKT_GEN_TKEEP_EN
        q_keep.delete();
`endif
        done_base = done_cnt;
        tick;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == done_base && n < 300) begin
            tick;
            n++;
        end
        tick;
        tick;
        cmp_cnt++;
        if (done_cnt !== done_base + 1) begin
            err_cnt++;
            $display("FAIL %s done_pulses: got %0d, need 1", name, done_cnt - done_base);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m_if.tready = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        cmp_cnt++;
        if ({m_if.tvalid, m_if.tlast, busy, done} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_flags: got valid/last/busy/done=%b, need 0000",
                     {m_if.tvalid, m_if.tlast, busy, done});
        end
        cmp_cnt++;
        if (m_if.tdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_tdata: got %h, need 00000000", m_if.tdata);
        end
        cmp_cnt++;
        if (pkt_count !== 16'd0) begin
            err_cnt++;
            $display("FAIL reset_pkt_count: got %0d, need 0", pkt_count);
        end
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [13:0] vtrace;
        m_if.tready = 1'b1;
        start_run(2'd0, 4'd4, 16'd2, 8'd0, 32'h10);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            vtrace[i] = m_if.tvalid;
        end
        tick;
        cmp_cnt++;
        if (vtrace !== 14'h00FF) begin
            err_cnt++;
            $display("FAIL b2b_valid_trace: got %b, need %b", vtrace, 14'h00FF);
        end
        cmp_cnt++;
        if (q_data.size() !== 8) begin
            err_cnt++;
            $display("FAIL b2b_beats: got %0d, need 8", q_data.size());
        end
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            cmp_cnt++;
            if (q_data[i] !== 32'h10 + 32'(i % 4) || q_last[i] !== (i % 4 == 3)) begin
                err_cnt++;
                $display("FAIL b2b_beat%0d: got data %h last %b, need %h last %b", i, q_data[i], q_last[i],
                         32'h10 + 32'(i % 4), (i % 4 == 3));
            end
        end
        cmp_cnt++;
        if (pkt_count !== 16'd2 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_status: got count %0d busy %b, need 2 0", pkt_count, busy);
        end
        cmp_cnt++;
        if (done_cnt !== done_base + 1) begin
            err_cnt++;
            $display("FAIL b2b_done: got %0d pulses, need 1", done_cnt - done_base);
        end
    endtask

    task automatic test_stall;
        logic          pv = 1'b0;
        logic          pr = 1'b0;
        logic          pl = 1'b0;
        logic [DW-1:0] pd = '0;
        m_if.tready = 1'b0;
        start_run(2'd0, 4'd3, 16'd1, 8'd0, 32'hA0);
        for (int k = 0; k < 18; k++) begin
            m_if.tready = (k % 3 == 0);
            @(negedge clk);
            if (pv && !pr) begin
                cmp_cnt++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== pd || m_if.tlast !== pl) begin
                    err_cnt++;
                    $display("FAIL stall_hold_k%0d: got v%b %h l%b, need v1 %h l%b", k, m_if.tvalid,
                             m_if.tdata, m_if.tlast, pd, pl);
                end
            end
            pv = m_if.tvalid; pr = m_if.tready; pd = m_if.tdata; pl = m_if.tlast;
            tick;
        end
        m_if.tready = 1'b1;
        cmp_cnt++;
        if (q_data.size() !== 3) begin
            err_cnt++;
            $display("FAIL stall_beats: got %0d, need 3", q_data.size());
        end
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            cmp_cnt++;
            if (q_data[i] !== 32'hA0 + 32'(i) || q_last[i] !== (i == 2)) begin
                err_cnt++;
                $display("FAIL stall_beat%0d: got %h last %b, need %h last %b", i, q_data[i], q_last[i],
                         32'hA0 + 32'(i), (i == 2));
            end
        end
        cmp_cnt++;
        if (done_cnt !== done_base + 1) begin
            err_cnt++;
            $display("FAIL stall_done: got %0d pulses, need 1", done_cnt - done_base);
        end
    endtask

    task automatic test_tag_gap;
        logic [15:0] vtrace;
        logic [DW-1:0] exp_d[6];
        exp_d = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0001_0001, 32'h0002_0000, 32'h0002_0001};
        m_if.tready = 1'b1;
        start_run(2'd2, 4'd2, 16'd3, 8'd3, 32'hDEAD_BEEF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vtrace[i] = m_if.tvalid;
        end
        tick;
        cmp_cnt++;
        if (vtrace !== 16'h0C63) begin
            err_cnt++;
            $display("FAIL gap_valid_trace: got %b, need %b", vtrace, 16'h0C63);
        end
        cmp_cnt++;
        if (q_data.size() !== 6) begin
            err_cnt++;
            $display("FAIL gap_beats: got %0d, need 6", q_data.size());
        end
        for (int i = 0; i < 6 && i < q_data.size(); i++) begin
            cmp_cnt++;
            if (q_data[i] !== exp_d[i] || q_last[i] !== (i % 2 == 1)) begin
                err_cnt++;
                $display("FAIL tag_beat%0d: got %h last %b, need %h last %b", i, q_data[i], q_last[i],
                         exp_d[i], (i % 2 == 1));
            end
        end
        cmp_cnt++;
        if (pkt_count !== 16'd3 || done_cnt !== done_base + 1) begin
            err_cnt++;
            $display("FAIL gap_status: got count %0d done %0d, need 3 1", pkt_count, done_cnt - done_base);
        end
    endtask

    task automatic test_stop_continuous;
        m_if.tready = 1'b1;
        start_run(2'd0, 4'd5, 16'd0, 8'd0, 32'h100);
        repeat (3) tick;
        cfg_start = 1'b1;
        cfg_seed = 32'h999;
        tick;
        cfg_start = 1'b0;
        repeat (12) tick;
        cfg_stop = 1'b1;
        tick;
        cfg_stop = 1'b0;
        wait_done("stop_run");
        cmp_cnt++;
        if (q_data.size() !== 20) begin
            err_cnt++;
            $display("FAIL stop_beats: got %0d, need 20", q_data.size());
        end
        for (int i = 0; i < 20 && i < q_data.size(); i++) begin
            cmp_cnt++;
            if (q_data[i] !== 32'h100 + 32'(i % 5) || q_last[i] !== (i % 5 == 4)) begin
                err_cnt++;
                $display("FAIL stop_beat%0d: got %h last %b, need %h last %b", i, q_data[i], q_last[i],
                         32'h100 + 32'(i % 5), (i % 5 == 4));
            end
        end
        cmp_cnt++;
        if (pkt_count !== 16'd4 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL stop_status: got count %0d busy %b, need 4 0", pkt_count, busy);
        end
    endtask

    task automatic test_stop_in_gap;
        m_if.tready = 1'b1;
        start_run(2'd1, 4'd1, 16'd0, 8'd5, 32'h77);
        tick;
        cfg_stop = 1'b1;
        tick;
        cfg_stop = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if ({done, busy, m_if.tvalid} !== 3'b100 || pkt_count !== 16'd1) begin
            err_cnt++;
            $display("FAIL gap_stop: got done/busy/valid=%b count %0d, need 100 count 1",
                     {done, busy, m_if.tvalid}, pkt_count);
        end
        tick;
    endtask

    task automatic test_reset_mid_packet;
        m_if.tready = 1'b1;
        start_run(2'd0, 4'd2, 16'd0, 8'd0, 32'h0);
        repeat (5) tick;
        m_if.tready = 1'b0;
        tick;
        cmp_cnt++;
        if (pkt_count !== 16'd2 || m_if.tvalid !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: got count %0d valid %b, need 2 1", pkt_count, m_if.tvalid);
        end
        reset = 1'b1;
        tick;
        @(negedge clk);
        cmp_cnt++;
        if ({m_if.tvalid, busy} !== 2'b00 || pkt_count !== 16'd0) begin
            err_cnt++;
            $display("FAIL mid_reset: got valid/busy=%b count %0d, need 00 count 0",
                     {m_if.tvalid, busy}, pkt_count);
        end
        tick;
        reset = 1'b0;
        m_if.tready = 1'b1;
    endtask

    task automatic test_len_rules;
        m_if.tready = 1'b1;
        start_run(2'd1, 4'd0, 16'd3, 8'd0, 32'h55);
        wait_done("len_zero");
        cmp_cnt++;
        if (q_data.size() !== 3) begin
            err_cnt++;
            $display("FAIL len0_beats: got %0d, need 3", q_data.size());
        end
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            cmp_cnt++;
            if (q_data[i] !== 32'h55 || q_last[i] !== 1'b1) begin
                err_cnt++;
                $display("FAIL len0_beat%0d: got %h last %b, need 00000055 last 1", i, q_data[i], q_last[i]);
            end
        end
        start_run(2'd3, 4'd12, 16'd1, 8'd0, 32'h0);
        wait_done("len_clamp");
        cmp_cnt++;
        if (q_data.size() !== MAXL) begin
            err_cnt++;
            $display("FAIL clamp_beats: got %0d, need %0d", q_data.size(), MAXL);
        end
        for (int i = 0; i < MAXL && i < q_data.size(); i++) begin
            cmp_cnt++;
            if (q_data[i] !== 32'(i) || q_last[i] !== (i == MAXL - 1)) begin
                err_cnt++;
                $display("FAIL clamp_beat%0d: got %h last %b, need %h last %b", i, q_data[i], q_last[i],
                         32'(i), (i == MAXL - 1));
            end
        end
    endtask

`ifdef AXIS_PKT_GEN_TKEEP_EN
    task automatic test_tkeep;
        logic [KW-1:0] exp_k[3];
        exp_k = '{4'hF, 4'hF, 4'h3};
        m_if.tready = 1'b1;
        cfg_last_keep = 4'b0011;
        start_run(2'd0, 4'd3, 16'd1, 8'd0, 32'h0);
        wait_done("tkeep_partial");
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if (i >= q_keep.size() || q_keep[i] !== exp_k[i]) begin
                err_cnt++;
                $display("FAIL tkeep_beat%0d: got %h, need %h", i, (i < q_keep.size()) ? q_keep[i] : 4'hx, exp_k[i]);
            end
        end
        cfg_last_keep = 4'b0000;
        start_run(2'd0, 4'd1, 16'd1, 8'd0, 32'h0);
        wait_done("tkeep_zero");
        cmp_cnt++;
        if (q_keep.size() !== 1 || q_keep[0] !== 4'hF) begin
            err_cnt++;
            $display("FAIL tkeep_zero: got %0d beats keep %h, need 1 beat keep F", q_keep.size(),
                     (q_keep.size() > 0) ? q_keep[0] : 4'hx);
        end
    endtask
`endif

    initial begin
        m_if.tready = 1'b0;
        test_reset;
        test_back_to_back;
        test_stall;
        test_tag_gap;
        test_stop_continuous;
        test_stop_in_gap;
        test_reset_mid_packet;
        test_len_rules;
`ifdef AXIS_PKT_GEN_TKEEP_EN
        test_tkeep;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
